// File: rtl/chess_move_tx.sv
// chess_move_tx
// -------------
// Serial transmitter for one chess move per packet. A move is taken from the
// move-validation stage over a valid/ready handshake and framed as a fixed
// 4-byte packet: header {6'b101000, msg_type}, from square, to square and an
// XOR checksum of the first three bytes. The packet is shifted out as 8N1
// UART, LSB first, back to back with no gap between bytes.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   move_valid in   1  move fields are presented
//   move_ready out  1  block can accept a move (idle)
//   msg_type   in   2  0 normal, 1 promotion, 2 resign, 3 reserved
//   from_sq    in   6  source square, rank*8 + file
//   to_sq      in   6  destination square, rank*8 + file
//   tx         out  1  serial line, idle high, driven from a register
//   busy       out  1  packet in flight, always the inverse of move_ready
module chess_move_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [1:0] msg_type,
    input  logic [5:0] from_sq,
    input  logic [5:0] to_sq,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [2:0] BIT_LAST  = 3'd7;
    localparam logic [1:0] BYTE_LAST = 2'd3;

    // A bit must last at least two clocks; smaller ratios cannot be framed.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_ratio
            $error("chess_move_tx: CLK_FREQ / BAUD must be at least 2");
        end
    endgenerate

    // Header byte carries a fixed 6-bit marker above the message type.
    function automatic logic [7:0] header_byte(input logic [1:0] mt);
        header_byte = {6'b101000, mt};
    endfunction

    // Checksum byte: XOR of header, from and to bytes.
    function automatic logic [7:0] checksum_byte(input logic [1:0] mt,
                                                 input logic [5:0] fs,
                                                 input logic [5:0] ts);
        checksum_byte = header_byte(mt) ^ {2'b00, fs} ^ {2'b00, ts};
    endfunction

    // Byte idx of the packet built from the latched move fields.
    function automatic logic [7:0] packet_byte(input logic [1:0] idx,
                                               input logic [1:0] mt,
                                               input logic [5:0] fs,
                                               input logic [5:0] ts);
        case (idx)
            2'd0:    packet_byte = header_byte(mt);
            2'd1:    packet_byte = {2'b00, fs};
            2'd2:    packet_byte = {2'b00, ts};
            2'd3:    packet_byte = checksum_byte(mt, fs, ts);
            default: packet_byte = 8'hFF;
        endcase
    endfunction

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [1:0]       byte_idx_r;
    logic [1:0]       msg_r;
    logic [5:0]       from_r;
    logic [5:0]       to_r;
    logic             tx_r;
    logic             ready_r;
    logic             busy_r;

    logic [1:0]       state_n_s;
    logic [CNT_W-1:0] cnt_n_s;
    logic [2:0]       bit_idx_n_s;
    logic [1:0]       byte_idx_n_s;
    logic             load_s;
    logic             accept_s;
    logic             cnt_last_s;
    logic [7:0]       cur_byte_s;
    logic             tx_n_s;
    logic             ready_n_s;

    assign accept_s   = move_valid && ready_r;
    assign cnt_last_s = (cnt_r == CNT_LAST);

    // Next-state, baud counter and bit/byte index sequencing.
    always_comb begin
        state_n_s    = state_r;
        cnt_n_s      = cnt_r + CNT_W'(1);
        bit_idx_n_s  = bit_idx_r;
        byte_idx_n_s = byte_idx_r;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n_s = '0;
                if (accept_s) begin
                    state_n_s    = ST_START;
                    bit_idx_n_s  = 3'd0;
                    byte_idx_n_s = 2'd0;
                    load_s       = 1'b1;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_last_s) begin
                    state_n_s   = ST_DATA;
                    cnt_n_s     = '0;
                    bit_idx_n_s = 3'd0;
                end else begin
                    state_n_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_last_s) begin
                    cnt_n_s = '0;
                    if (bit_idx_r == BIT_LAST) begin
                        state_n_s   = ST_STOP;
                        bit_idx_n_s = 3'd0;
                    end else begin
                        bit_idx_n_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_n_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_last_s) begin
                    cnt_n_s = '0;
                    if (byte_idx_r == BYTE_LAST) begin
                        state_n_s    = ST_IDLE;
                        byte_idx_n_s = 2'd0;
                    end else begin
                        state_n_s    = ST_START;
                        byte_idx_n_s = byte_idx_r + 2'd1;
                    end
                end else begin
                    state_n_s = ST_STOP;
                end
            end
            default: begin
                state_n_s    = ST_IDLE;
                cnt_n_s      = '0;
                bit_idx_n_s  = 3'd0;
                byte_idx_n_s = 2'd0;
            end
        endcase
    end

    // The byte being framed next cycle; the fields are already latched
    // whenever the next state is DATA, so no bypass of the inputs is needed.
    assign cur_byte_s = packet_byte(byte_idx_n_s, msg_r, from_r, to_r);

    // Line level for the next cycle, so tx changes on the same edge as the
    // state it belongs to (start bit begins at the accept edge).
    always_comb begin
        tx_n_s = 1'b1;
        case (state_n_s)
            ST_IDLE:  tx_n_s = 1'b1;
            ST_START: tx_n_s = 1'b0;
            ST_DATA:  tx_n_s = cur_byte_s[bit_idx_n_s];
            ST_STOP:  tx_n_s = 1'b1;
            default:  tx_n_s = 1'b1;
        endcase
    end

    assign ready_n_s = (state_n_s == ST_IDLE);

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 2'd0;
            tx_r       <= 1'b1;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            cnt_r      <= cnt_n_s;
            bit_idx_r  <= bit_idx_n_s;
            byte_idx_r <= byte_idx_n_s;
            tx_r       <= tx_n_s;
            ready_r    <= ready_n_s;
            busy_r     <= !ready_n_s;
        end
    end

    // Move field capture at the handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_r  <= 2'b00;
            from_r <= 6'd0;
            to_r   <= 6'd0;
        end else if (load_s) begin
            msg_r  <= msg_type;
            from_r <= from_sq;
            to_r   <= to_sq;
        end
    end

    assign tx         = tx_r;
    assign move_ready = ready_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_chess_move_tx.sv
// Bench for chess_move_tx: a packet-level reference model predicts tx,
// move_ready and busy on every cycle, a UART decoder recovers bytes from tx,
// and directed scenarios pin literal byte values and timings.
module tb_chess_move_tx;

    localparam int N  = 4;
    localparam int NB = 434;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       move_valid;
    logic [1:0] msg_type;
    logic [5:0] from_sq;
    logic [5:0] to_sq;
    logic       move_ready;
    logic       tx;
    logic       busy;

    logic       mv_b;
    logic [1:0] mt_b;
    logic [5:0] fs_b;
    logic [5:0] ts_b;
    logic       rdy_b;
    logic       tx_b;
    logic       busy_b;

    chess_move_tx #(.CLK_FREQ(400), .BAUD(100)) dut (
        .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move_ready(move_ready),
        .msg_type(msg_type), .from_sq(from_sq), .to_sq(to_sq), .tx(tx), .busy(busy)
    );

    chess_move_tx #(.CLK_FREQ(50_000_000), .BAUD(115_200)) dut_b (
        .clk(clk), .rst_n(rst_n), .move_valid(mv_b), .move_ready(rdy_b),
        .msg_type(mt_b), .from_sq(fs_b), .to_sq(ts_b), .tx(tx_b), .busy(busy_b)
    );

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] mk_byte(input int i, input logic [1:0] mt,
                                           input logic [5:0] f, input logic [5:0] t);
        logic [7:0] b0, b1, b2;
        b0 = 8'hA0 + {6'd0, mt};
        b1 = {2'b00, f};
        b2 = {2'b00, t};
        case (i)
            0:       return b0;
            1:       return b1;
            2:       return b2;
            default: return b0 ^ b1 ^ b2;
        endcase
    endfunction

    int         cyc = 0;
    bit         fl  = 1'b0;
    int         e0  = 0;
    bit         pbits [40];
    logic [7:0] exp_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (fl) begin
                if (cyc - e0 == 40 * N) fl = 1'b0;
            end else if (move_valid) begin
                fl = 1'b1;
                e0 = cyc;
                for (int i = 0; i < 4; i++) begin
                    logic [7:0] b;
                    b = mk_byte(i, msg_type, from_sq, to_sq);
                    exp_q.push_back(b);
                    pbits[i*10] = 1'b0;
                    for (int k = 0; k < 8; k++) pbits[i*10+1+k] = b[k];
                    pbits[i*10+9] = 1'b1;
                end
            end
        end
    end

    bit check_en = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            logic exp_tx;
            exp_tx = fl ? pbits[(cyc - e0) / N] : 1'b1;
            chk("tx", {31'd0, tx}, {31'd0, exp_tx});
            chk("move_ready", {31'd0, move_ready}, {31'd0, !fl});
            chk("busy", {31'd0, busy}, {31'd0, fl});
        end
    end

    // ---------------- UART decoder on tx ----------------
    bit         dbusy = 1'b0;
    int         dj    = 0;
    logic [7:0] dsh;
    logic [7:0] got [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            dbusy = 1'b0;
        end else if (!dbusy) begin
            if (tx === 1'b0) begin
                dbusy = 1'b1;
                dj    = 0;
            end
        end else begin
            dj++;
            if (dj % N == N / 2) begin
                int k;
                k = dj / N;
                if (k <= 8) begin
                    dsh[k-1] = tx;
                end else begin
                    chk("stop_bit", {31'd0, tx}, 32'd1);
                    got.push_back(dsh);
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL unexpected_byte: got 0x%0h required none", dsh);
                    end else begin
                        chk("decoded_byte", {24'd0, dsh}, {24'd0, exp_q.pop_front()});
                    end
                    dbusy = 1'b0;
                end
            end
        end
    end

    int tcyc = 0;
    always @(posedge clk) tcyc++;

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] mt, input logic [5:0] f, input logic [5:0] t);
        @(negedge clk);
        msg_type   = mt;
        from_sq    = f;
        to_sq      = t;
        move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    task automatic wait_done(output int lowcyc);
        bit ok;
        ok     = 1'b0;
        lowcyc = 0;
        for (int i = 0; i < 2000; i++) begin
            if (move_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            lowcyc++;
            @(negedge clk);
        end
        if (!ok) begin
            nvec++;
            nfail++;
            $display("FAIL wait_done_timeout: got busy required idle within 2000 cycles");
        end
    endtask

    task automatic chk_got(input string name, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int base);
        logic [7:0] e [4];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
        for (int i = 0; i < 4; i++) begin
            if (got.size() > base + i)
                chk(name, {24'd0, got[base+i]}, {24'd0, e[i]});
            else
                chk(name, 32'hFFFF_FFFF, {24'd0, e[i]});
        end
    endtask

    initial begin
        int lowc, t1, t2, drops, bcnt, lowrun;
        bit ok, seen_hi;

        rst_n      = 1'b0;
        move_valid = 1'b0;
        msg_type   = 2'd0;
        from_sq    = 6'd0;
        to_sq      = 6'd0;
        mv_b       = 1'b0;
        mt_b       = 2'd0;
        fs_b       = 6'd0;
        ts_b       = 6'd0;
        check_en   = 1'b1;

        // 1. reset and idle line
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_ready", {31'd0, move_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        drops = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) drops++;
        end
        chk("idle_tx_drops", drops, 32'd0);

        // 2. single move
        got.delete();
        send(2'd0, 6'd12, 6'd28);
        wait_done(lowc);
        chk("single_ready_low", lowc, 32'd160);
        chk_got("single_bytes", 8'hA0, 8'h0C, 8'h1C, 8'hB0, 0);

        // 3. back-to-back with move_valid held high
        repeat (3) @(negedge clk);
        got.delete();
        msg_type = 2'd0; from_sq = 6'd12; to_sq = 6'd28; move_valid = 1'b1;
        @(negedge clk);
        chk("bb_first_accept", {31'd0, move_ready}, 32'd0);
        t1 = tcyc;
        msg_type = 2'd2; from_sq = 6'd63; to_sq = 6'd0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (move_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        for (int i = 0; i < 10 && ok; i++) begin
            if (move_ready === 1'b0) break;
            @(negedge clk);
        end
        t2 = tcyc;
        move_valid = 1'b0;
        chk("bb_accept_spacing", t2 - t1, 32'd161);
        wait_done(lowc);
        chk_got("bb_bytes1", 8'hA0, 8'h0C, 8'h1C, 8'hB0, 0);
        chk_got("bb_bytes2", 8'hA2, 8'h3F, 8'h00, 8'h9D, 4);

        // 4. valid pulse and field changes during B1 are ignored
        repeat (2) @(negedge clk);
        got.delete();
        send(2'd1, 6'd5, 6'd40);
        repeat (50) @(negedge clk);
        msg_type = 2'd3; from_sq = 6'd63; to_sq = 6'd63; move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        msg_type = 2'd0; from_sq = 6'd1; to_sq = 6'd2;
        wait_done(lowc);
        repeat (60) @(negedge clk);
        chk("ign_byte_count", got.size(), 32'd4);
        chk_got("ign_bytes", 8'hA1, 8'h05, 8'h28, 8'h8C, 0);

        // 5. asynchronous reset during bit 3 of B2
        send(2'd0, 6'd1, 6'd4);
        repeat (97) @(negedge clk);
        chk("pre_reset_tx", {31'd0, tx}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_tx", {31'd0, tx}, 32'd1);
        chk("async_reset_ready", {31'd0, move_ready}, 32'd1);
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {31'd0, move_ready}, 32'd1);
        got.delete();
        send(2'd2, 6'd10, 6'd20);
        wait_done(lowc);
        chk("post_reset_ready_low", lowc, 32'd160);
        chk_got("post_reset_bytes", 8'hA2, 8'h0A, 8'h14, 8'hBC, 0);

        // Randomised moves with random gaps and ignored traffic while busy
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            msg_type   = 2'($urandom_range(0, 3));
            from_sq    = 6'($urandom_range(0, 63));
            to_sq      = 6'($urandom_range(0, 63));
            move_valid = 1'b1;
            @(negedge clk);
            ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (move_ready === 1'b1) begin ok = 1'b1; break; end
                msg_type   = 2'($urandom_range(0, 3));
                from_sq    = 6'($urandom_range(0, 63));
                to_sq      = 6'($urandom_range(0, 63));
                move_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            move_valid = 1'b0;
            if (!ok) begin
                nvec++;
                nfail++;
                $display("FAIL random_timeout: got busy required idle within 400 cycles");
            end
        end
        repeat (5) @(negedge clk);
        chk("pending_bytes", exp_q.size(), 32'd0);

        // 6. baud scaling on the N=434 instance
        @(negedge clk);
        chk("b_idle_ready", {31'd0, rdy_b}, 32'd1);
        chk("b_idle_tx", {31'd0, tx_b}, 32'd1);
        mt_b = 2'd1; fs_b = 6'd0; ts_b = 6'd0; mv_b = 1'b1;
        @(negedge clk);
        mv_b    = 1'b0;
        bcnt    = 0;
        lowrun  = 0;
        seen_hi = 1'b0;
        ok      = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (busy_b !== 1'b1) begin ok = 1'b1; break; end
            bcnt++;
            if (!seen_hi) begin
                if (tx_b === 1'b0) lowrun++;
                else seen_hi = 1'b1;
            end
            @(negedge clk);
        end
        chk("b_completed", {31'd0, ok}, 32'd1);
        chk("b_packet_cycles", bcnt, 32'd17360);
        chk("b_bit_width", lowrun, NB);
        chk("b_end_tx", {31'd0, tx_b}, 32'd1);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
